// File: rtl/aha_req_ack_receiver.sv
// Destination-side four-phase REQ/ACK controller: qualify REQ_SYNC, pulse START, await DONE (with timeout), hold ACK until REQ drops.
// Latency: START one cycle after the MIN_HIGH-th high sample; ACK one cycle after DONE/timeout; ACK falls one cycle after REQ low sample.
module aha_req_ack_receiver #(
    parameter int MIN_HIGH       = 2,
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic REQ_SYNC,
    input  logic DONE,
    input  logic ERR_CLR,
    output logic START,
    output logic ACK,
    output logic BUSY,
    output logic TIMEOUT_ERR
);

    localparam logic [3:0]           MIN_Q  = 4'(MIN_HIGH);
    localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam bit                   TO_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        QUAL      = 3'd1,
        FIRE      = 3'd2,
        WAIT_DONE = 3'd3,
        ACK_HI    = 3'd4
    } state_t;

    state_t               state;
    logic [3:0]           q_cnt;
    logic [TIMEOUT_W-1:0] t_cnt;

    // All outputs are flops updated alongside the state so nothing glitches toward the source domain.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= IDLE;
            q_cnt       <= '0;
            t_cnt       <= '0;
            START       <= 1'b0;
            ACK         <= 1'b0;
            BUSY        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            START <= 1'b0;
            if (ERR_CLR) begin
                TIMEOUT_ERR <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (REQ_SYNC) begin
                        if (MIN_HIGH == 1) begin
                            state <= FIRE;
                            q_cnt <= '0;
                            START <= 1'b1;
                            BUSY  <= 1'b1;
                        end else begin
                            state <= QUAL;
                            q_cnt <= 4'd1;
                        end
                    end
                end
                QUAL: begin
                    if (!REQ_SYNC) begin
                        state <= IDLE;
                        q_cnt <= '0;
                    end else if ((q_cnt + 4'd1) == MIN_Q) begin
                        state <= FIRE;
                        q_cnt <= '0;
                        START <= 1'b1;
                        BUSY  <= 1'b1;
                    end else begin
                        q_cnt <= q_cnt + 4'd1;
                    end
                end
                FIRE: begin
                    t_cnt <= '0;
                    if (DONE) begin
                        state <= ACK_HI;
                        ACK   <= 1'b1;
                    end else begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // DONE takes priority over an expiring timeout, so the error flag stays clear.
                    if (DONE) begin
                        state <= ACK_HI;
                        ACK   <= 1'b1;
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                        if (TO_EN && ((t_cnt + 1'b1) == TO_LIM)) begin
                            state       <= ACK_HI;
                            ACK         <= 1'b1;
                            TIMEOUT_ERR <= 1'b1;
                        end
                    end
                end
                ACK_HI: begin
                    if (!REQ_SYNC) begin
                        state <= IDLE;
                        q_cnt <= '0;
                        ACK   <= 1'b0;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    q_cnt <= '0;
                    ACK   <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aha_req_ack_receiver.sv
// Bench for aha_req_ack_receiver: transaction-level model compared every cycle, plus directed literal checks.
module tb_aha_req_ack_receiver;

    localparam int MIN_HIGH = 2;
    localparam int TO       = 4;

    logic CLK = 1'b0;
    logic RESETn;
    logic req, done, clr;
    logic START, ACK, BUSY, TIMEOUT_ERR;

    int vectors     = 0;
    int miscompares = 0;
    int start_cnt   = 0;
    bit chk_en      = 0;

    // Model: a handshake is either not in progress, waiting for completion, or acknowledged.
    int run;
    bit in_x;
    bit acked;
    int since;
    bit m_err;

    always #5 CLK = ~CLK;

    aha_req_ack_receiver #(
        .MIN_HIGH(MIN_HIGH),
        .TIMEOUT_W(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .REQ_SYNC(req),
        .DONE(done),
        .ERR_CLR(clr),
        .START(START),
        .ACK(ACK),
        .BUSY(BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    function void model_reset();
        run   = 0;
        in_x  = 0;
        acked = 0;
        since = 0;
        m_err = 0;
    endfunction

    function void model_step();
        bit set_err;
        set_err = 0;
        if (!in_x) begin
            if (req) begin
                run++;
                if (run >= MIN_HIGH) begin
                    in_x  = 1;
                    acked = 0;
                    since = 0;
                    run   = 0;
                end
            end else begin
                run = 0;
            end
        end else if (!acked) begin
            if (done) begin
                acked = 1;
            end else if (TO != 0 && since != 0 && since == TO) begin
                acked   = 1;
                set_err = 1;
            end else begin
                since++;
            end
        end else if (!req) begin
            in_x  = 0;
            acked = 0;
        end
        if (set_err) m_err = 1;
        else if (clr) m_err = 0;
    endfunction

    always @(negedge CLK) begin
        if (START === 1'b1) start_cnt++;
        if (chk_en) begin
            logic e_start, e_ack, e_busy, e_err;
            e_start = in_x && !acked && (since == 0);
            e_ack   = acked;
            e_busy  = in_x;
            e_err   = m_err;
            vectors++;
            if (START !== e_start || ACK !== e_ack || BUSY !== e_busy || TIMEOUT_ERR !== e_err) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t got start/ack/busy/err=%b%b%b%b required %b%b%b%b",
                         $time, START, ACK, BUSY, TIMEOUT_ERR, e_start, e_ack, e_busy, e_err);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic d, input logic c);
        req  = r;
        done = d;
        clr  = c;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    // Asynchronous reset pulse taken mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset(input string name);
        #1 RESETn = 1'b0;
        model_reset();
        #1;
        chk({name, "_start"}, int'(START), 0);
        chk({name, "_ack"}, int'(ACK), 0);
        chk({name, "_busy"}, int'(BUSY), 0);
        chk({name, "_err"}, int'(TIMEOUT_ERR), 0);
        @(posedge CLK);
        @(negedge CLK);
        #2 RESETn = 1'b1;
    endtask

    initial begin
        int s0;
        logic rq;
        RESETn = 1'b0;
        req = 0; done = 0; clr = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("reset_start", int'(START), 0);
        chk("reset_ack", int'(ACK), 0);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_err", int'(TIMEOUT_ERR), 0);
        #2 RESETn = 1'b1;
        chk_en = 1;

        // Basic handshake
        step(1, 0, 0);
        chk("basic_qual_start", int'(START), 0);
        chk("basic_qual_busy", int'(BUSY), 0);
        step(1, 0, 0);
        chk("basic_fire_start", int'(START), 1);
        chk("basic_fire_busy", int'(BUSY), 1);
        step(1, 0, 0);
        chk("basic_wait_start", int'(START), 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("basic_ack_before_done", int'(ACK), 0);
        step(1, 1, 0);
        chk("basic_ack_rise", int'(ACK), 1);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("basic_ack_held", int'(ACK), 1);
        step(0, 0, 0);
        chk("basic_ack_fall", int'(ACK), 0);
        chk("basic_busy_fall", int'(BUSY), 0);
        chk("basic_no_err", int'(TIMEOUT_ERR), 0);

        // Glitch rejection
        s0 = start_cnt;
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("glitch_starts", start_cnt - s0, 0);
        chk("glitch_busy", int'(BUSY), 0);

        // Timeout, then sticky error until ERR_CLR
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("to_ack_before", int'(ACK), 0);
        step(1, 0, 0);
        chk("to_ack_rise", int'(ACK), 1);
        chk("to_err_set", int'(TIMEOUT_ERR), 1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("to_err_sticky", int'(TIMEOUT_ERR), 1);
        step(0, 0, 1);
        chk("to_err_clr", int'(TIMEOUT_ERR), 0);

        // DONE in the FIRE cycle
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        chk("fire_done_ack", int'(ACK), 1);
        step(0, 0, 0);

        // DONE coincident with the timeout cycle
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        chk("done_vs_to_ack", int'(ACK), 1);
        chk("done_vs_to_err", int'(TIMEOUT_ERR), 0);
        step(0, 0, 0);

        // Reset while ACK=1 with the error flag set
        repeat (7) step(1, 0, 0);
        chk("rst_pre_ack", int'(ACK), 1);
        chk("rst_pre_err", int'(TIMEOUT_ERR), 1);
        do_reset("rst_mid");
        s0 = start_cnt;
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        repeat (5) step(1, 0, 0);
        chk("rst_requal_starts", start_cnt - s0, 1);
        step(0, 0, 0);

        // Back-to-back requests
        s0 = start_cnt;
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("b2b_second_start", int'(START), 1);
        step(1, 1, 0);
        step(0, 0, 0);
        chk("b2b_starts", start_cnt - s0, 2);

        // Random traffic
        rq = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
            if ($urandom_range(0, 3) == 0) rq = ~rq;
            step(rq, ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
